wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of write-back queue entries (legal range 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have ports alu_valid in 1, alu_ready out 1, alu_dest in 3, alu_data in 16: the ALU result producer.
REQ-005 SHALL have ports ld_valid in 1, ld_ready out 1, ld_dest in 3, ld_data in 16: the load-data producer.
REQ-006 SHALL have ports reg_write_en out 1, reg_write_dest out 3, reg_write_data out 16, driving the register-file write port.
REQ-007 SHALL have ports byp_addr_1 in 3, byp_addr_2 in 3, byp_hit_1 out 1, byp_data_1 out 16, byp_hit_2 out 1, byp_data_2 out 16 for operand bypass.
REQ-008 SHALL have status ports count out 4 (current occupancy), full out 1, empty out 1.

Function
REQ-009 SHALL hold entries {dest[2:0], data[15:0]} in a circular FIFO with wrapping read and write pointers.
REQ-010 SHALL compute free = DEPTH - count from registered state only; ready outputs SHALL NOT depend on the same-cycle pop.
REQ-011 SHALL drive ld_ready = (free >= 1) and alu_ready = (free >= 2) or (free == 1 and ld_valid == 0); on contention the load has priority.
REQ-012 SHALL accept a producer when its valid and ready are both high; both may be accepted in one cycle.
REQ-013 SHALL enqueue the ALU entry ahead of the load entry when both are accepted in the same cycle; the load entry is younger.
REQ-014 SHALL drive reg_write_en = !empty, with reg_write_dest and reg_write_data taken combinationally from the head entry.
REQ-015 SHALL pop the head every cycle in which it is non-empty; the register file always accepts the write.
REQ-016 SHALL give a minimum latency of one cycle: an entry accepted at edge N is presented on the write port during cycle N+1.
REQ-017 SHALL update count = count + pushes - pop, where push, push and pop in the same cycle are legal and count never exceeds DEPTH.
REQ-018 SHALL wrap each pointer from DEPTH-1 to 0.
REQ-019 SHALL drive full = (count == DEPTH) and empty = (count == 0).
REQ-020 SHALL set byp_hit_k = 1 when any valid entry, including the head being written this cycle, has dest == byp_addr_k, with byp_data_k taken from the youngest matching entry.
REQ-021 SHALL drive byp_data_k = 0 whenever byp_hit_k = 0.
REQ-022 SHALL NOT accept entries, and outputs SHALL NOT be X, while valid is low, whatever the values on the dest and data inputs.

Reset
REQ-023 SHALL, when reset is high at a rising clk edge, clear both pointers and count to 0, discarding any in-flight entries.
REQ-024 SHALL give every output its empty-state value from reset: reg_write_en 0, dest 0, data 0, full 0, empty 1, count 0, byp_hit 0, byp_data 0, alu_ready 1, ld_ready 1.
REQ-025 SHALL give reset priority over simultaneous pushes and pops, so no entry is accepted on a reset edge.

Configuration
REQ-026 SHALL include the bypass search of REQ-020 only when macro WB_QUEUE_BYPASS_EN is defined.
REQ-027 SHALL, without WB_QUEUE_BYPASS_EN, keep the byp_* ports present but tie byp_hit_1, byp_hit_2, byp_data_1 and byp_data_2 to constant 0.

Structure
REQ-028 SHALL take the shared constants REG_ADDR_W = 3, DATA_W = 16 and the entry typedef {dest, data} from the shared package risc_pkg.
REQ-029 SHALL implement the youngest-match search as the sub-module wb_bypass_match, instantiated once per read port.

Verification
REQ-030 Scenario: ALU pushes dest 3 data 0x1234 alone -> next cycle reg_write_en 1, dest 3, data 0x1234; the cycle after, empty 1.
REQ-031 Scenario: ALU (dest 1, 0x00AA) and load (dest 2, 0x00BB) pushed in the same cycle -> writes dest 1 then dest 2 on consecutive cycles; count goes 2, 1, 0.
REQ-032 Scenario: queue holds DEPTH-1 entries while both producers are valid -> ld_ready 1, alu_ready 0; only the load is accepted.
REQ-033 Scenario: entries dest 5 0x0001 (older) and dest 5 0x0002 (younger) queued, byp_addr_1 = 5 -> byp_hit_1 1, byp_data_1 0x0002; byp_addr_2 = 6 -> hit 0, data 0.
REQ-034 Scenario: reset asserted with 3 entries queued and a push pending -> next cycle count 0, reg_write_en 0, and the pushed entry is dropped.
REQ-035 Scenario: 20 back-to-back pushes with incrementing data -> writes come out in order and pointers wrap with no loss; without WB_QUEUE_BYPASS_EN, byp_hit is always 0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared write-back constants, queue entry type and pointer helper.
package risc_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 16;
    localparam int MAX_DEPTH  = 8;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    localparam wb_entry_t ENTRY_ZERO = '{dest: 3'd0, data: 16'd0};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                 input logic [CNT_W-1:0] depth);
        if ({1'b0, ptr} == depth - 4'd1) begin
            return 3'd0;
        end else begin
            return ptr + 3'd1;
        end
    endfunction

endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the live queue entries for one bypass read port.
module wb_bypass_match
    import risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t              entries [MAX_DEPTH],
    input  logic [PTR_W-1:0]       rd_ptr,
    input  logic [CNT_W-1:0]       count,
    input  logic [REG_ADDR_W-1:0]  addr,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] idx_s;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit   = 1'b0;
        data  = 16'd0;
        idx_s = rd_ptr;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (entries[idx_s].dest == addr)) begin
                hit  = 1'b1;
                data = entries[idx_s].data;
            end else begin
                hit  = hit;
                data = data;
            end
            idx_s = ptr_inc(idx_s, DEPTH_C);
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue merging ALU and load results into one register-file write port.
// Operand bypass search is built only when WB_QUEUE_BYPASS_EN is defined.
module wb_queue
    import risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [2:0]  alu_dest,
    input  logic [15:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [2:0]  ld_dest,
    input  logic [15:0] ld_data,
    output logic        reg_write_en,
    output logic [2:0]  reg_write_dest,
    output logic [15:0] reg_write_data,
    input  logic [2:0]  byp_addr_1,
    input  logic [2:0]  byp_addr_2,
    output logic        byp_hit_1,
    output logic [15:0] byp_data_1,
    output logic        byp_hit_2,
    output logic [15:0] byp_data_2,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_entry_t         mem_q [MAX_DEPTH];
    wb_entry_t         mem_d [MAX_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  free_s;
    logic              alu_push_s, ld_push_s, pop_s;
    wb_entry_t         head_s;

    // Handshake, enqueue order (ALU before load) and occupancy update.
    always_comb begin
        free_s     = DEPTH_C - count_q;
        ld_ready   = (free_s >= 4'd1);
        alu_ready  = (free_s >= 4'd2) || ((free_s == 4'd1) && !ld_valid);
        alu_push_s = alu_valid && alu_ready;
        ld_push_s  = ld_valid && ld_ready;
        pop_s      = (count_q != 4'd0);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (alu_push_s) begin
            mem_d[wr_ptr_d] = '{dest: alu_dest, data: alu_data};
            wr_ptr_d        = ptr_inc(wr_ptr_d, DEPTH_C);
        end else begin
            wr_ptr_d = wr_ptr_d;
        end
        if (ld_push_s) begin
            mem_d[wr_ptr_d] = '{dest: ld_dest, data: ld_data};
            wr_ptr_d        = ptr_inc(wr_ptr_d, DEPTH_C);
        end else begin
            wr_ptr_d = wr_ptr_d;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q, DEPTH_C);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {3'd0, alu_push_s} + {3'd0, ld_push_s} - {3'd0, pop_s};
    end

    // Queue state; reset wins over any same-edge push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 3'd0;
            wr_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            for (int i = 0; i < MAX_DEPTH; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head entry drives the write port; gated so an empty queue shows zeros.
    always_comb begin
        head_s         = mem_q[rd_ptr_q];
        reg_write_en   = pop_s;
        if (pop_s) begin
            reg_write_dest = head_s.dest;
            reg_write_data = head_s.data;
        end else begin
            reg_write_dest = 3'd0;
            reg_write_data = 16'd0;
        end
        count = count_q;
        full  = (count_q == DEPTH_C);
        empty = (count_q == 4'd0);
    end

`ifdef WB_QUEUE_BYPASS_EN
    wb_bypass_match #(.DEPTH(DEPTH)) u_byp_1 (
        .entries (mem_q),
        .rd_ptr  (rd_ptr_q),
        .count   (count_q),
        .addr    (byp_addr_1),
        .hit     (byp_hit_1),
        .data    (byp_data_1)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_byp_2 (
        .entries (mem_q),
        .rd_ptr  (rd_ptr_q),
        .count   (count_q),
        .addr    (byp_addr_2),
        .hit     (byp_hit_2),
        .data    (byp_data_2)
    );
`else
    logic unused_byp_s;
    assign unused_byp_s = ^{byp_addr_1, byp_addr_2};
    assign byp_hit_1    = 1'b0;
    assign byp_data_1   = 16'd0;
    assign byp_hit_2    = 1'b0;
    assign byp_data_2   = 16'd0;
`endif

endmodule
